uart_tx_sched: RTL and testbench
================================

UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
- REQ-001 SHALL have parameter NREQ, default 2: number of byte requesters.
- REQ-002 SHALL have parameter CSR_SEL, default 4'h0: value driven on csr_a[13:10] to select the target uart.
- REQ-003 SHALL have parameter TIMEOUT, default 4096: maximum cycles to wait for tx_irq after a data write.
- REQ-004 SHALL have port sys_clk, input, 1: single clock; all logic on its rising edge.
- REQ-005 SHALL have port sys_rst, input, 1: reset, synchronous and active-high.
- REQ-006 SHALL have port req_valid, input, NREQ: requester i has a byte pending.
- REQ-007 SHALL have port req_data, input, NREQ*8: byte of requester i in bits [8i+7:8i].
- REQ-008 SHALL have port req_ready, output, NREQ: one-hot grant; the byte transfers when valid & ready.
- REQ-009 SHALL have port csr_a, output, 14: uart CSR address.
- REQ-010 SHALL have port csr_we, output, 1: uart CSR write strobe.
- REQ-011 SHALL have port csr_di, output, 32: uart CSR write data.
- REQ-012 SHALL have port tx_irq, input, 1: one-cycle pulse from the uart at transmit completion.
- REQ-013 SHALL have port busy, output, 1: high in INIT, WRITE and WAIT.
- REQ-014 SHALL have port grant_id, output, $clog2(NREQ): index of the last accepted requester.
- REQ-015 SHALL have port err_clr, input, 1: clears timeout_err.
- REQ-016 SHALL have port timeout_err, output, 1: sticky flag; tx_irq was not seen within TIMEOUT cycles.

Function
- REQ-017 SHALL implement the states INIT, IDLE, WRITE and WAIT.
- REQ-018 INIT SHALL last exactly 1 cycle, with csr_we=1, csr_a={CSR_SEL,8'h00,2'b10} and csr_di=32'h0 (thru mode off), then go to IDLE.
- REQ-019 In IDLE, req_ready SHALL combinationally assert only for the arbitration winner among req_valid, and SHALL be all-zero in every other state.
- REQ-020 On acceptance the block SHALL latch the byte and the winner index (grant_id), then enter WRITE on the next cycle.
- REQ-021 WRITE SHALL last exactly 1 cycle, with csr_we=1, csr_a={CSR_SEL,8'h00,2'b00} and csr_di={24'h0,byte}, then go to WAIT.
- REQ-022 csr_we SHALL be 0 outside INIT and WRITE, and csr_a/csr_di SHALL hold their last driven values.
- REQ-023 In WAIT, tx_irq=1 SHALL return the block to IDLE on the next cycle; tx_irq SHALL be ignored in all other states.
- REQ-024 The WAIT counter SHALL start at 0 on WAIT entry; on reaching TIMEOUT-1 without tx_irq, the block SHALL set timeout_err and go to IDLE.
- REQ-025 If tx_irq arrives in the same cycle the count reaches TIMEOUT-1, tx_irq SHALL win and timeout_err SHALL stay unchanged.
- REQ-026 Arbitration SHALL default to round-robin: the search starts at the index after the last grant and wraps from NREQ-1 to 0.
- REQ-027 A byte SHALL be accepted from IDLE and written in the next cycle, so that the csr_we pulse occurs 1 cycle after acceptance.
- REQ-028 With no req_valid, the block SHALL stay in IDLE with req_ready=0.
- REQ-029 err_clr SHALL clear timeout_err; if set and clear occur in the same cycle, set SHALL win.

Reset
- REQ-030 On sys_rst=1, the block SHALL go to INIT and set csr_we=0, csr_a=0, csr_di=0, req_ready=0, grant_id=0, timeout_err=0, the round-robin pointer to NREQ-1 and the WAIT counter to 0.
- REQ-031 A reset asserted during WRITE or WAIT SHALL drop the in-flight byte, and INIT SHALL rerun after reset is released.

Configuration
- REQ-032 When UART_TX_SCHED_PRIO_EN is defined, arbitration SHALL be fixed priority (lowest index wins) and the round-robin pointer SHALL be omitted.
- REQ-033 When UART_TX_SCHED_PRIO_EN is undefined, arbitration SHALL be round-robin per REQ-026.

Structure
- REQ-034 Package uart_sched_pkg SHALL hold the state enum, the register offsets REG_RXTX=2'b00 and REG_THRU=2'b10, and the csr_a build function.
- REQ-035 The arbiter SHALL be a sub-module uart_rr_arb (request vector and advance in, one-hot grant out), containing the macro-controlled priority mode.

Verification
- REQ-036 Reset release SHALL produce one csr_we pulse with csr_a=14'h0002 and csr_di=0, then busy=0.
- REQ-037 Requester 0 sending 8'hab SHALL be accepted, followed 1 cycle later by csr_we with csr_a=14'h0000 and csr_di=32'h000000ab; a tx_irq 20 cycles later SHALL return the block to IDLE.
- REQ-038 With both requesters continuously valid (0:8'h11, 1:8'h22), round-robin SHALL grant 0,1,0,1, and with UART_TX_SCHED_PRIO_EN defined SHALL grant 0,0,0.
- REQ-039 With no tx_irq for TIMEOUT=16 cycles, timeout_err SHALL assert at cycle 16 of WAIT; an err_clr applied together with a new timeout SHALL leave timeout_err at 1.
- REQ-040 A sys_rst asserted during WAIT SHALL return the block to INIT, INIT SHALL rerun after release, and the dropped byte SHALL never be rewritten.

Source files
------------

// File: rtl/uart_sched_pkg.sv
// Shared types and helpers for the uart transmit scheduler: FSM state
// encoding, uart CSR register offsets and the CSR address builder.
package uart_sched_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_WRITE = 2'd2,
        ST_WAIT  = 2'd3
    } sched_state_e;

    localparam logic [1:0] REG_RXTX = 2'b00;
    localparam logic [1:0] REG_THRU = 2'b10;

    // The top four address bits select the uart; the low two pick its register.
    function automatic logic [13:0] csr_addr(input logic [3:0] sel, input logic [1:0] off);
        return {sel, 8'h00, off};
    endfunction

endpackage

// File: rtl/uart_rr_arb.sv
// One-hot arbiter over NREQ requesters. Round-robin by default; defining
// UART_TX_SCHED_PRIO_EN selects fixed priority (lowest index wins).
module uart_rr_arb
    import uart_sched_pkg::*;
#(
    parameter int N = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N-1:0] req_i,
    input  logic         adv_i,
    output logic [N-1:0] gnt_o
);

`ifdef UART_TX_SCHED_PRIO_EN

    logic found;
    logic unused_ok;

    assign unused_ok = ^{clk_i, rst_i, adv_i};

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req_i[i] && !found) begin
                gnt_o[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

`else

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] win_idx;
    logic [IW:0]   sum;
    logic          found;

    // ptr_q holds the last granted index; the search starts one past it.
    always_comb begin
        gnt_o   = '0;
        win_idx = '0;
        sum     = '0;
        found   = 1'b0;
        for (int off = 1; off <= N; off++) begin
            sum = {1'b0, ptr_q} + (IW+1)'(off);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            if (!found && req_i[sum[IW-1:0]]) begin
                gnt_o[sum[IW-1:0]] = 1'b1;
                win_idx            = sum[IW-1:0];
                found              = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (adv_i) begin
            ptr_d = win_idx;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= IW'(N - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

`endif

endmodule

// File: rtl/uart_tx_sched.sv
// Arbitrates byte requesters onto one uart: programs thru-mode off once, then
// writes each granted byte and waits for tx_irq (bounded by TIMEOUT).
// Build option: UART_TX_SCHED_PRIO_EN selects fixed-priority arbitration.
module uart_tx_sched
    import uart_sched_pkg::*;
#(
    parameter int         NREQ    = 2,
    parameter logic [3:0] CSR_SEL = 4'h0,
    parameter int         TIMEOUT = 4096
) (
    input  logic                                          sys_clk,
    input  logic                                          sys_rst,
    input  logic [NREQ-1:0]                               req_valid,
    input  logic [NREQ*8-1:0]                             req_data,
    output logic [NREQ-1:0]                               req_ready,
    output logic [13:0]                                   csr_a,
    output logic                                          csr_we,
    output logic [31:0]                                   csr_di,
    input  logic                                          tx_irq,
    output logic                                          busy,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0]    grant_id,
    input  logic                                          err_clr,
    output logic                                          timeout_err,
    output logic [1:0]                                    dbg_state
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    sched_state_e  state_q, state_d;
    logic [7:0]    byte_q, byte_d;
    logic [GW-1:0] gid_q, gid_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          err_set;
    logic [13:0]   csr_a_q;
    logic [31:0]   csr_di_q;

    logic [NREQ-1:0] arb_gnt;
    logic [GW-1:0]   win_idx;
    logic [7:0]      win_byte;
    logic            accept;

    uart_rr_arb #(.N(NREQ)) u_arb (
        .clk_i (sys_clk),
        .rst_i (sys_rst),
        .req_i (req_valid),
        .adv_i (accept),
        .gnt_o (arb_gnt)
    );

    // Handshake: req_ready is the one-hot grant, offered only in IDLE; a byte
    // moves on a cycle where req_valid[i] & req_ready[i], and valid may drop after.
    assign req_ready = (state_q == ST_IDLE) ? arb_gnt : '0;
    assign accept    = |(req_valid & req_ready);

    always_comb begin
        win_idx  = '0;
        win_byte = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                win_idx  = GW'(i);
                win_byte = req_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        byte_d  = byte_q;
        gid_d   = gid_q;
        cnt_d   = cnt_q;
        err_set = 1'b0;
        case (state_q)
            ST_INIT: begin
                state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (accept) begin
                    byte_d  = win_byte;
                    gid_d   = win_idx;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            default: begin
                // tx_irq beats the timeout when both land on the last count.
                if (tx_irq) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    err_set = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        if (err_set) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // CSR bus is live only in INIT/WRITE; otherwise it replays the last write.
    always_comb begin
        csr_we = 1'b0;
        csr_a  = csr_a_q;
        csr_di = csr_di_q;
        if (!sys_rst) begin
            if (state_q == ST_INIT) begin
                csr_we = 1'b1;
                csr_a  = csr_addr(CSR_SEL, REG_THRU);
                csr_di = 32'h0;
            end else if (state_q == ST_WRITE) begin
                csr_we = 1'b1;
                csr_a  = csr_addr(CSR_SEL, REG_RXTX);
                csr_di = {24'h0, byte_q};
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q  <= ST_INIT;
            byte_q   <= '0;
            gid_q    <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            csr_a_q  <= '0;
            csr_di_q <= '0;
        end else begin
            state_q  <= state_d;
            byte_q   <= byte_d;
            gid_q    <= gid_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            csr_a_q  <= csr_a;
            csr_di_q <= csr_di;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign grant_id    = gid_q;
    assign timeout_err = err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: reset/INIT write, single transfers,
// tx_irq/timeout boundary, err_clr priority, reset mid-WAIT and arbitration order.
module tb_uart_tx_sched;
    import uart_sched_pkg::*;

    localparam int NREQ = 2;

    logic              sys_clk;
    logic              sys_rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*8-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic [13:0]       csr_a;
    logic              csr_we;
    logic [31:0]       csr_di;
    logic              tx_irq;
    logic              busy;
    logic [0:0]        grant_id;
    logic              err_clr;
    logic              timeout_err;
    logic [1:0]        dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    logic [45:0] exp_q[$];

    uart_tx_sched #(
        .NREQ    (NREQ),
        .CSR_SEL (4'h0),
        .TIMEOUT (16)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .csr_a       (csr_a),
        .csr_we      (csr_we),
        .csr_di      (csr_di),
        .tx_irq      (tx_irq),
        .busy        (busy),
        .grant_id    (grant_id),
        .err_clr     (err_clr),
        .timeout_err (timeout_err),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge sys_clk);
    endtask

    // Offer one byte from requester idx at an IDLE point; returns at the WRITE cycle.
    task automatic send(input int idx, input logic [7:0] b);
        req_valid = NREQ'(1) << idx;
        req_data  = 16'(b) << (8 * idx);
        #1;
        check("ready_onehot", 32'(req_ready), 32'(1 << idx));
        exp_q.push_back({14'h0000, 24'h0, b});
        cyc();
        req_valid = '0;
        #1;
        check("write_we", 32'(csr_we), 1);
        check("write_addr", 32'(csr_a), 32'h0000);
        check("write_data", csr_di, {24'h0, b});
        check("write_gid", 32'(grant_id), idx);
        check("write_ready_low", 32'(req_ready), 0);
    endtask

    // scoreboard: every csr_we pulse must match the head of exp_q
    initial begin
        logic [45:0] e;
        forever begin
            @(negedge sys_clk);
            #2;
            if (csr_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("wr_unexpected", {18'h0, csr_a}, 32'hffff_ffff);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(csr_a), 32'(e[45:32]));
                    check("wr_data", csr_di, e[31:0]);
                end
            end
        end
    end

    // driver
    initial begin
        int g;
        int we_cnt;

        sys_rst   = 1'b1;
        req_valid = '0;
        req_data  = '0;
        tx_irq    = 1'b0;
        err_clr   = 1'b0;

        repeat (3) cyc();
        #1;
        check("rst_we", 32'(csr_we), 0);
        check("rst_addr", 32'(csr_a), 0);
        check("rst_data", csr_di, 0);
        check("rst_ready", 32'(req_ready), 0);
        check("rst_gid", 32'(grant_id), 0);
        check("rst_err", 32'(timeout_err), 0);

        // INIT: thru-mode off written once, then IDLE
        cyc();
        sys_rst = 1'b0;
        exp_q.push_back({14'h0002, 32'h0});
        #1;
        check("init_we", 32'(csr_we), 1);
        check("init_addr", 32'(csr_a), 32'h0002);
        check("init_data", csr_di, 0);
        check("init_state", 32'(dbg_state), 32'(ST_INIT));
        cyc();
        #1;
        check("idle_we", 32'(csr_we), 0);
        check("idle_busy", 32'(busy), 0);
        check("idle_addr_hold", 32'(csr_a), 32'h0002);

        // requester 0 sends 8'hab; tx_irq ends WAIT
        cyc();
        send(0, 8'hab);
        repeat (14) cyc();
        #1;
        check("wait_busy", 32'(busy), 1);
        cyc();
        tx_irq = 1'b1;
        cyc();
        tx_irq = 1'b0;
        #1;
        check("irq_idle", 32'(dbg_state), 32'(ST_IDLE));
        check("irq_busy", 32'(busy), 0);
        check("irq_err", 32'(timeout_err), 0);

        // tx_irq on the last count wins over timeout
        cyc();
        send(1, 8'h3c);
        repeat (15) cyc();
        cyc();
        tx_irq = 1'b1;
        #1;
        check("edge_state", 32'(dbg_state), 32'(ST_WAIT));
        cyc();
        tx_irq = 1'b0;
        #1;
        check("edge_busy", 32'(busy), 0);
        check("edge_err", 32'(timeout_err), 0);

        // tx_irq in IDLE is ignored
        cyc();
        tx_irq = 1'b1;
        cyc();
        tx_irq = 1'b0;
        #1;
        check("irq_idle_ign", 32'(dbg_state), 32'(ST_IDLE));

        // timeout after 16 WAIT cycles
        cyc();
        send(0, 8'h7e);
        repeat (16) cyc();
        #1;
        check("to_pre_busy", 32'(busy), 1);
        check("to_pre_err", 32'(timeout_err), 0);
        cyc();
        #1;
        check("to_err", 32'(timeout_err), 1);
        check("to_idle", 32'(dbg_state), 32'(ST_IDLE));

        cyc();
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        #1;
        check("clr_err", 32'(timeout_err), 0);

        // set beats clear in the same cycle
        cyc();
        send(1, 8'h81);
        repeat (15) cyc();
        cyc();
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        #1;
        check("set_wins", 32'(timeout_err), 1);

        // reset during WAIT drops the byte and reruns INIT
        cyc();
        send(0, 8'h5c);
        repeat (3) cyc();
        sys_rst = 1'b1;
        cyc();
        cyc();
        #1;
        check("rst2_we", 32'(csr_we), 0);
        check("rst2_err", 32'(timeout_err), 0);
        check("rst2_addr", 32'(csr_a), 0);
        check("rst2_state", 32'(dbg_state), 32'(ST_INIT));
        cyc();
        sys_rst = 1'b0;
        exp_q.push_back({14'h0002, 32'h0});
        #1;
        check("rst2_init_we", 32'(csr_we), 1);
        check("rst2_init_addr", 32'(csr_a), 32'h0002);
        we_cnt = 0;
        repeat (20) begin
            cyc();
            #1;
            if (csr_we === 1'b1) we_cnt++;
        end
        check("rst2_no_rewrite", we_cnt, 0);

        // both requesters continuously valid
        cyc();
        req_valid = 2'b11;
        req_data  = 16'h2211;
        for (int k = 0; k < 4; k++) begin
`ifdef UART_TX_SCHED_PRIO_EN
            g = 0;
`else
            g = k % 2;
`endif
            #1;
            check("arb_ready", 32'(req_ready), 32'(1 << g));
            exp_q.push_back({14'h0000, 24'h0, (g == 0) ? 8'h11 : 8'h22});
            cyc();
            #1;
            check("arb_gid", 32'(grant_id), g);
            check("arb_data", csr_di, (g == 0) ? 32'h11 : 32'h22);
            cyc();
            tx_irq = 1'b1;
            cyc();
            tx_irq = 1'b0;
        end
        req_valid = '0;

        // no requests: stay idle
        repeat (4) begin
            cyc();
            #1;
            check("none_ready", 32'(req_ready), 0);
            check("none_busy", 32'(busy), 0);
        end

        cyc();
        cyc();
        check("exp_q_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
